// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the SEQ Y86 stage sequencer.
// Holds the stage encoding (visible on the stage output) and the Y86 Stat codes.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StPcupd     = 3'd6,
        StHalt      = 3'd7
    } state_e;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // TIMEOUT is limited to 255, so an 8-bit wait counter always suffices.
    localparam int unsigned WaitCntW = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-latency watchdog shared by the FETCH and MEMORY states.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, clears the count
//   clear_i     synchronous clear (held while no request is outstanding)
//   count_en_i  request high without ack this cycle
//   expired_o   count has reached TIMEOUT-1
module seq_wait_timer
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [WaitCntW-1:0] Limit = WaitCntW'(TIMEOUT - 1);

    logic [WaitCntW-1:0] cnt_q;
    logic [WaitCntW-1:0] cnt_d;

    assign expired_o = (cnt_q == Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expired_o) begin
            // Saturate at the limit; the sequencer leaves the wait state anyway.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the SEQ Y86 core.
// Walks each instruction through FETCH, DECODE, EXECUTE, (MEMORY), WRITEBACK and
// PCUPD, issues one-cycle write strobes, runs the memory handshakes under a
// watchdog and owns the architectural Stat register.
// Ports:
//   Clk, Reset                clock; asynchronous active-low reset
//   Run, Step                 start enable; return to IDLE after each instruction
//   imem_ack/error, instr_valid   fetch completion and its qualifiers
//   is_halt, need_dmem, set_cc    instruction attributes (sampled in PCUPD/EXECUTE)
//   dmem_ack/error            data access completion and qualifier
//   imem_req, dmem_req        memory requests
//   cc_en, reg_wen, pc_en     state-register write strobes
//   stage, stat, halted       current stage, Y86 status, halt flag
//   retired                   retired-instruction count (wraps)
module seq_stage_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Step,
    input  logic             imem_ack,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             is_halt,
    input  logic             need_dmem,
    input  logic             set_cc,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             cc_en,
    output logic             reg_wen,
    output logic             pc_en,
    output logic [2:0]       stage,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       stat_q;
    logic [2:0]       stat_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    logic wait_clear;
    logic wait_count;
    logic wait_expired;

    // Counter is held at zero outside the two wait states, so it starts fresh
    // on every entry to FETCH or MEMORY.
    assign wait_clear = !((state_q == StFetch) || (state_q == StMemory));
    assign wait_count = ((state_q == StFetch) && !imem_ack) ||
                        ((state_q == StMemory) && !dmem_ack);

    seq_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .clear_i    (wait_clear),
        .count_en_i (wait_count),
        .expired_o  (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        cc_en     = 1'b0;
        reg_wen   = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;

        case (state_q)
            StIdle: begin
                if (Run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_req = 1'b1;
                // An ack in the same cycle as expiry wins over the watchdog.
                if (imem_ack) begin
                    if (imem_error) begin
                        stat_d  = SADR;
                        state_d = StHalt;
                    end else if (!instr_valid) begin
                        stat_d  = SINS;
                        state_d = StHalt;
                    end else begin
                        state_d = StDecode;
                    end
                end else if (wait_expired) begin
                    stat_d  = SADR;
                    state_d = StHalt;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                cc_en   = set_cc;
                state_d = need_dmem ? StMemory : StWriteback;
            end
            StMemory: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (dmem_error) begin
                        stat_d  = SADR;
                        state_d = StHalt;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (wait_expired) begin
                    stat_d  = SADR;
                    state_d = StHalt;
                end
            end
            StWriteback: begin
                reg_wen = 1'b1;
                state_d = StPcupd;
            end
            StPcupd: begin
                pc_en     = 1'b1;
                retired_d = retired_q + 1'b1;
                if (is_halt) begin
                    stat_d  = SHLT;
                    state_d = StHalt;
                end else if (Step || !Run) begin
                    state_d = StIdle;
                end else begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            stat_q    <= SAOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    assign stage   = state_q;
    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl. Each instruction is described at the
// transaction level (fetch wait, memory wait, errors, halt); a generator expands
// it into the expected per-cycle stage/stat/retired trace plus the inputs to drive.
module tb_seq_stage_ctrl;

    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 4;
    localparam int          LIM = int'(TO) - 1;

    logic          Clk;
    logic          Reset;
    logic          Run, Step;
    logic          imem_ack, imem_error, instr_valid, is_halt;
    logic          need_dmem, set_cc, dmem_ack, dmem_error;
    logic          imem_req, dmem_req, cc_en, reg_wen, pc_en, halted;
    logic [2:0]    stage, stat;
    logic [CW-1:0] retired;

    seq_stage_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Step       (Step),
        .imem_ack   (imem_ack),
        .imem_error (imem_error),
        .instr_valid(instr_valid),
        .is_halt    (is_halt),
        .need_dmem  (need_dmem),
        .set_cc     (set_cc),
        .dmem_ack   (dmem_ack),
        .dmem_error (dmem_error),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .cc_en      (cc_en),
        .reg_wen    (reg_wen),
        .pc_en      (pc_en),
        .stage      (stage),
        .stat       (stat),
        .halted     (halted),
        .retired    (retired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          run, step, iack, ierr, ivld, hlt, nd, cc, dack, derr;
        logic [2:0]    stg;
        logic [2:0]    st;
        logic [CW-1:0] ret;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   cmp_en;

    int m_stat, m_ret;
    int n_checks, n_errors;
    int cyc, last_pc, pc_gap;
    int cnt_imem, cnt_dmem, cnt_cc, cnt_wen, cnt_pc, cnt_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] stg, input logic run, input logic step,
                        input logic iack, input logic ierr, input logic ivld, input logic hlt,
                        input logic nd, input logic cc, input logic dack, input logic derr);
        cyc_t c;
        c.stg = stg; c.run = run; c.step = step; c.iack = iack; c.ierr = ierr;
        c.ivld = ivld; c.hlt = hlt; c.nd = nd; c.cc = cc; c.dack = dack; c.derr = derr;
        c.st  = 3'(m_stat);
        c.ret = CW'(m_ret);
        q.push_back(c);
    endtask

    // A cycle where only Run/Step matter; the rest carry deliberately hostile values.
    task automatic pj(input logic [2:0] stg, input logic run, input logic step);
        push(stg, run, step, 1, 1, 0, 1, 1, 1, 1, 1);
    endtask

    // Expected trace of one instruction starting in FETCH. fw/dw = wait cycles
    // before ack (beyond the watchdog limit means no ack at all).
    task automatic gen_instr(input int fw, input logic ierr, input logic ivld, input logic nd,
                             input int dw, input logic derr, input logic cc, input logic hlt,
                             input logic run_late, input logic step, output logic stopped);
        stopped = 1'b1;
        if (fw > LIM) begin
            for (int i = 0; i <= LIM; i++) push(3'd1, 1, step, 0, 1, 0, 1, 1, 1, 1, 1);
            m_stat = 3;
            return;
        end
        for (int i = 0; i < fw; i++) push(3'd1, 1, step, 0, 1, 0, 1, 1, 1, 1, 1);
        push(3'd1, 1, step, 1, ierr, ivld, 1, 1, 1, 1, 1);
        if (ierr) begin m_stat = 3; return; end
        if (!ivld) begin m_stat = 4; return; end
        pj(3'd2, 1, step);
        push(3'd3, run_late, step, 1, 1, 0, 1, nd, cc, 1, 1);
        if (nd) begin
            if (dw > LIM) begin
                for (int i = 0; i <= LIM; i++) push(3'd4, run_late, step, 1, 1, 0, 1, 1, 1, 0, 1);
                m_stat = 3;
                return;
            end
            for (int i = 0; i < dw; i++) push(3'd4, run_late, step, 1, 1, 0, 1, 1, 1, 0, 1);
            push(3'd4, run_late, step, 1, 1, 0, 1, 1, 1, 1, derr);
            if (derr) begin m_stat = 3; return; end
        end
        pj(3'd5, run_late, step);
        push(3'd6, run_late, step, 1, 1, 0, hlt, 1, 1, 1, 1);
        m_ret = (m_ret + 1) % (1 << CW);
        if (hlt) begin m_stat = 2; return; end
        stopped = 1'b0;
    endtask

    task automatic apply(input cyc_t c);
        Run = c.run; Step = c.step; imem_ack = c.iack; imem_error = c.ierr;
        instr_valid = c.ivld; is_halt = c.hlt; need_dmem = c.nd; set_cc = c.cc;
        dmem_ack = c.dack; dmem_error = c.derr;
    endtask

    task automatic run_q();
        while (q.size() > 0) begin
            @(negedge Clk);
            cur = q.pop_front();
            apply(cur);
            cmp_en = 1'b1;
        end
        @(negedge Clk);
        cmp_en = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_imem = 0; cnt_dmem = 0; cnt_cc = 0; cnt_wen = 0; cnt_pc = 0; cnt_busy = 0;
        last_pc = -100; pc_gap = 0;
    endtask

    task automatic do_reset();
        cmp_en = 1'b0;
        Reset = 1'b0;
        Run = 0; Step = 0; imem_ack = 0; imem_error = 0; instr_valid = 0; is_halt = 0;
        need_dmem = 0; set_cc = 0; dmem_ack = 0; dmem_error = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        m_stat = 1;
        m_ret = 0;
        clr_cnt();
    endtask

    // Compare process: outputs follow from the expected stage by the stage rules.
    initial begin
        cyc = 0;
        forever begin
            @(negedge Clk);
            #2;
            if (cmp_en) begin
                cyc++;
                chk("stage", 32'(stage), 32'(cur.stg));
                chk("imem_req", 32'(imem_req), 32'(cur.stg == 3'd1));
                chk("dmem_req", 32'(dmem_req), 32'(cur.stg == 3'd4));
                chk("cc_en", 32'(cc_en), 32'((cur.stg == 3'd3) && cur.cc));
                chk("reg_wen", 32'(reg_wen), 32'(cur.stg == 3'd5));
                chk("pc_en", 32'(pc_en), 32'(cur.stg == 3'd6));
                chk("halted", 32'(halted), 32'(cur.stg == 3'd7));
                chk("stat", 32'(stat), 32'(cur.st));
                chk("retired", 32'(retired), 32'(cur.ret));
                if (imem_req === 1'b1) cnt_imem++;
                if (dmem_req === 1'b1) cnt_dmem++;
                if (cc_en === 1'b1) cnt_cc++;
                if (reg_wen === 1'b1) cnt_wen++;
                if (stage >= 3'd1 && stage <= 3'd6) cnt_busy++;
                if (pc_en === 1'b1) begin
                    cnt_pc++;
                    pc_gap  = cyc - last_pc;
                    last_pc = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stp;
        n_checks = 0; n_errors = 0; cmp_en = 1'b0;

        // Reset values
        do_reset();
        Reset = 1'b0;
        #1;
        chk("rst_stage", 32'(stage), 0);
        chk("rst_stat", 32'(stat), 1);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_outs", 32'({imem_req, dmem_req, cc_en, reg_wen, pc_en, halted}), 0);

        // Three plain instructions then halt
        do_reset();
        pj(3'd0, 0, 0);
        pj(3'd0, 1, 0);
        gen_instr(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, stp);
        gen_instr(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, stp);
        gen_instr(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, stp);
        gen_instr(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, stp);
        repeat (3) pj(3'd7, 1, 0);
        run_q();
        chk("halt_retired", 32'(retired), 4);
        chk("halt_stat", 32'(stat), 2);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_pc_pulses", cnt_pc, 4);
        chk("halt_pc_gap", pc_gap, 5);
        chk("halt_cc_pulses", cnt_cc, 2);

        // Memory instruction, ack after 3 wait cycles, Step=1
        do_reset();
        pj(3'd0, 1, 1);
        gen_instr(0, 0, 1, 1, 3, 0, 0, 0, 1, 1, stp);
        repeat (2) pj(3'd0, 0, 1);
        run_q();
        chk("mem_dmem_cycles", cnt_dmem, 4);
        chk("mem_wen", cnt_wen, 1);
        chk("mem_busy_cycles", cnt_busy, 9);
        chk("mem_retired", 32'(retired), 1);
        chk("mem_stage_idle", 32'(stage), 0);

        // Data address error: no writeback, no PC update
        clr_cnt();
        pj(3'd0, 1, 0);
        gen_instr(1, 0, 1, 1, 1, 1, 1, 0, 1, 0, stp);
        repeat (2) pj(3'd7, 0, 0);
        run_q();
        chk("derr_stat", 32'(stat), 3);
        chk("derr_wen", cnt_wen, 0);
        chk("derr_pc", cnt_pc, 0);

        // Fetch watchdog expiry
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(40, 0, 1, 0, 0, 0, 0, 0, 1, 0, stp);
        repeat (2) pj(3'd7, 1, 0);
        run_q();
        chk("ito_imem_cycles", cnt_imem, 16);
        chk("ito_stat", 32'(stat), 3);
        chk("ito_halted", 32'(halted), 1);
        chk("ito_pc", cnt_pc, 0);

        // Ack in the last watchdog cycle wins
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(15, 0, 1, 0, 0, 0, 1, 1, 1, 0, stp);
        repeat (2) pj(3'd7, 1, 0);
        run_q();
        chk("iack_last_imem", cnt_imem, 16);
        chk("iack_last_retired", 32'(retired), 1);
        chk("iack_last_stat", 32'(stat), 2);

        // Data watchdog expiry
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(0, 0, 1, 1, 40, 0, 0, 0, 1, 0, stp);
        repeat (2) pj(3'd7, 1, 0);
        run_q();
        chk("dto_dmem_cycles", cnt_dmem, 16);
        chk("dto_stat", 32'(stat), 3);

        // Illegal opcode
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, stp);
        repeat (2) pj(3'd7, 1, 0);
        run_q();
        chk("ins_stat", 32'(stat), 4);
        chk("ins_strobes", cnt_cc + cnt_wen + cnt_pc, 0);

        // Fetch error has priority over illegal opcode
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, stp);
        repeat (2) pj(3'd7, 1, 0);
        run_q();
        chk("iadr_stat", 32'(stat), 3);
        chk("iadr_strobes", cnt_cc + cnt_wen + cnt_pc, 0);

        // Single step, then Run dropped during EXECUTE
        do_reset();
        pj(3'd0, 1, 1);
        gen_instr(1, 0, 1, 0, 0, 0, 1, 0, 1, 1, stp);
        repeat (2) pj(3'd0, 0, 1);
        pj(3'd0, 1, 1);
        gen_instr(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, stp);
        pj(3'd0, 1, 0);
        gen_instr(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, stp);
        repeat (2) pj(3'd0, 0, 0);
        run_q();
        chk("step_retired", 32'(retired), 3);
        chk("step_pc", cnt_pc, 3);
        chk("step_stage", 32'(stage), 0);

        // Retired counter wraps (CNT_W=4)
        do_reset();
        pj(3'd0, 1, 0);
        for (int i = 0; i < 17; i++) gen_instr(0, 0, 1, 0, 0, 0, 0, (i == 16), 1, 0, stp);
        pj(3'd7, 1, 0);
        run_q();
        chk("wrap_retired", 32'(retired), 1);
        chk("wrap_stat", 32'(stat), 2);

        // Asynchronous reset while a data request is outstanding
        do_reset();
        pj(3'd0, 1, 0);
        gen_instr(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, stp);
        push(3'd1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1);
        pj(3'd2, 1, 0);
        push(3'd3, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1);
        repeat (2) push(3'd4, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1);
        run_q();
        chk("pre_rst_dmem_req", 32'(dmem_req), 1);
        chk("pre_rst_retired", 32'(retired), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_stage", 32'(stage), 0);
        chk("arst_dmem_req", 32'(dmem_req), 0);
        chk("arst_stat", 32'(stat), 1);
        chk("arst_retired", 32'(retired), 0);
        chk("arst_outs", 32'({imem_req, cc_en, reg_wen, pc_en, halted}), 0);
        @(negedge Clk);
        Reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Multi-cycle stage sequencer for the SEQ Y86 core. It walks each instruction through fetch, decode, execute, memory, writeback and PC-update.
- It generates one-cycle enable strobes for the PC, condition-code and register-file state registers.
- It runs the request/acknowledge handshakes to instruction and data memory, supervises memory latency with a watchdog, and owns the architectural status (Stat) register.

Parameters:
- TIMEOUT, 16: maximum cycles a memory request may wait for ack before a fault is declared. Range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately
- Run  in  1  level; 1 allows instructions to be started
- Step  in  1  level; 1 means return to IDLE after each retired instruction
- imem_ack  in  1  instruction memory has completed the current fetch
- imem_error  in  1  fetch address invalid; qualified by imem_ack
- instr_valid  in  1  fetched opcode legal; qualified by imem_ack
- is_halt  in  1  current instruction is halt; sampled in PCUPD
- need_dmem  in  1  current instruction accesses data memory; sampled in EXECUTE
- set_cc  in  1  current instruction updates CC; sampled in EXECUTE
- dmem_ack  in  1  data memory has completed the current access
- dmem_error  in  1  data address invalid; qualified by dmem_ack
- imem_req  out  1  fetch request, held until ack or timeout
- dmem_req  out  1  data request, held until ack or timeout
- cc_en  out  1  CC register write strobe
- reg_wen  out  1  register-file write strobe
- pc_en  out  1  PC register write strobe
- stage  out  3  current state encoding
- stat  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4
- halted  out  1  1 while in HALT
- retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, stat=AOK, retired=0, wait counter=0.
  - All req and strobe outputs are 0, halted=0.
  - Asserting Reset mid-request drops the request at once; the memory side must tolerate an abandoned request.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
- Output decode: all outputs are decoded from the state register plus the qualifying inputs only. There are no registered output copies.
- IDLE: when Run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1.
  - On imem_ack: if imem_error, stat<=ADR and go to HALT; else if !instr_valid, stat<=INS and go to HALT; else go to DECODE.
  - imem_error takes priority over !instr_valid.
- DECODE: 1 cycle, then EXECUTE.
- EXECUTE: cc_en=set_cc this cycle. Next state is MEMORY if need_dmem, else WRITEBACK.
- MEMORY:
  - dmem_req=1.
  - On dmem_ack: if dmem_error, stat<=ADR and go to HALT, with no writeback and no PC update; else go to WRITEBACK.
- WRITEBACK: reg_wen=1 for exactly 1 cycle, then PCUPD.
- PCUPD:
  - pc_en=1 for 1 cycle; retired<=retired+1, wrapping modulo 2^CNT_W.
  - If is_halt: stat<=HLT and go to HALT.
  - Else if Step=1 or Run=0: go to IDLE.
  - Else go to FETCH.
- HALT: halted=1 and all strobes and requests are 0. Leave only via Reset.
- Run deasserted mid-instruction has no effect until PCUPD; the instruction always completes.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEMORY and increments on each cycle the request is high without ack.
  - If the counter reaches TIMEOUT-1 without ack: stat<=ADR, go to HALT, and the request drops next cycle.
  - If ack arrives in the same cycle the counter reaches TIMEOUT-1, ack wins and the counter value is ignored.
- Latency: an immediate same-cycle ack gives 5 cycles per instruction without a memory access, 6 with one. Each extra wait cycle adds 1.
- stat changes only on the transitions listed above and is never cleared except by Reset.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the state encoding constants (IDLE..HALT);
  - the Stat codes SAOK, SHLT, SADR, SINS.
- One sub-module, seq_wait_timer:
  - inputs: clear, count-enable;
  - output: expired, asserted when the count reaches TIMEOUT-1;
  - parameterised by TIMEOUT; shared by the FETCH and MEMORY states.

Test Plan:
- Run=1, Step=0; acks same cycle; 3 non-memory instructions then is_halt on the 4th -> pc_en pulses every 5 cycles; retired=4; stat=2; halted=1.
- Instruction with need_dmem=1 and dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; reg_wen 1 cycle after ack; 9 cycles total from FETCH entry to PCUPD exit.
- imem_ack withheld with TIMEOUT=16 -> imem_req high exactly 16 cycles; then stat=3 (ADR), halted=1, pc_en never pulses. Repeat with ack in the 16th cycle -> DECODE entered, stat=1.
- imem_ack with instr_valid=0 -> stat=4 (INS); imem_ack with imem_error=1 and instr_valid=0 -> stat=3 (ADR); in both cases cc_en, reg_wen and pc_en stay 0.
- Step=1, Run=1 -> exactly one instruction retires per IDLE→FETCH entry; dropping Run during EXECUTE still completes the instruction (retired+1), then IDLE.
- Reset driven low while in MEMORY with dmem_req=1 -> all outputs go to reset values before the next Clk edge; stat=1, retired=0.
